// File: rtl/tdm_demux4.sv
// tdm_demux4: 1:4 time-division demultiplexer.
// Receives a serial word stream framed by fsync and distributes each valid
// word to one of four registered channel outputs by its slot position.
// A HUNT/LOCK framing FSM tracks alignment: an early fsync resynchronises,
// and a missing fsync drops back to HUNT.
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         fsync,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [3:0]   y_valid,
    output logic         frame_valid,
    output logic         sync_err,
    output logic         locked
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [W-1:0] yData_q [4];
    logic [W-1:0] yData_d [4];
    logic [3:0]   yValid_q, yValid_d;
    logic         frameValid_q, frameValid_d;
    logic         syncErr_q, syncErr_d;

    // Framing decision and channel routing for the word presented this cycle;
    // idle cycles leave everything as-is and keep all strobes low.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        yData_d      = yData_q;
        yValid_d     = 4'b0000;
        frameValid_d = 1'b0;
        syncErr_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (fsync) begin
                        yData_d[0] = din;
                        yValid_d   = 4'b0001;
                        slot_d     = 2'd1;
                        state_d    = LOCK;
                    end
                end
                LOCK: begin
                    if (fsync) begin
                        if (slot_q != 2'd0) begin
                            syncErr_d = 1'b1;
                        end
                        yData_d[0] = din;
                        yValid_d   = 4'b0001;
                        slot_d     = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        syncErr_d = 1'b1;
                        slot_d    = 2'd0;
                        state_d   = HUNT;
                    end else begin
                        yData_d[slot_q]  = din;
                        yValid_d[slot_q] = 1'b1;
                        slot_d           = slot_q + 2'd1;
                        if (slot_q == 2'd3) begin
                            frameValid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    // State, slot counter, channel data and strobes, with synchronous reset
    // taking priority over any word presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= 2'd0;
            yData_q[0]   <= '0;
            yData_q[1]   <= '0;
            yData_q[2]   <= '0;
            yData_q[3]   <= '0;
            yValid_q     <= 4'b0000;
            frameValid_q <= 1'b0;
            syncErr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            yData_q[0]   <= yData_d[0];
            yData_q[1]   <= yData_d[1];
            yData_q[2]   <= yData_d[2];
            yData_q[3]   <= yData_d[3];
            yValid_q     <= yValid_d;
            frameValid_q <= frameValid_d;
            syncErr_q    <= syncErr_d;
        end
    end

    assign y0          = yData_q[0];
    assign y1          = yData_q[1];
    assign y2          = yData_q[2];
    assign y3          = yData_q[3];
    assign y_valid     = yValid_q;
    assign frame_valid = frameValid_q;
    assign sync_err    = syncErr_q;
    assign locked      = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: table-driven bench for tdm_demux4.
// Each vector holds the inputs for one clock edge and the hand-derived
// outputs expected after that edge; expectations are queued as stimulus is
// driven and popped when the DUT outputs are sampled.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         fsync;
    logic [W-1:0] y0, y1, y2, y3;
    logic [3:0]   y_valid;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;

    typedef struct {
        logic         rst;
        logic         dv;
        logic         fs;
        logic [W-1:0] din;
        logic [W-1:0] ey0;
        logic [W-1:0] ey1;
        logic [W-1:0] ey2;
        logic [W-1:0] ey3;
        logic [3:0]   eyv;
        logic         efv;
        logic         ese;
        logic         elk;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    tdm_demux4 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .y_valid     (y_valid),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck run still ends with a report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic r, logic dv, logic fs, logic [W-1:0] d,
                                logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] c, logic [W-1:0] e,
                                logic [3:0] yv, logic fv, logic se, logic lk);
        vec_t v;
        v.rst = r;  v.dv = dv;  v.fs = fs;  v.din = d;
        v.ey0 = a;  v.ey1 = b;  v.ey2 = c;  v.ey3 = e;
        v.eyv = yv; v.efv = fv; v.ese = se; v.elk = lk;
        return v;
    endfunction

    task automatic cmp(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    // Drive one vector at the falling edge and queue its expectation
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        din_valid = v.dv;
        fsync     = v.fs;
        din       = v.din;
        expQ.push_back(v);
    endtask

    // Sample just after the rising edge and compare against the oldest expectation
    task automatic checkOutput(input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard vec %0d: got empty queue expected entry", idx);
        end else begin
            e = expQ.pop_front();
            cmp("y0",          idx, 32'(y0),          32'(e.ey0));
            cmp("y1",          idx, 32'(y1),          32'(e.ey1));
            cmp("y2",          idx, 32'(y2),          32'(e.ey2));
            cmp("y3",          idx, 32'(y3),          32'(e.ey3));
            cmp("y_valid",     idx, 32'(y_valid),     32'(e.eyv));
            cmp("frame_valid", idx, 32'(frame_valid), 32'(e.efv));
            cmp("sync_err",    idx, 32'(sync_err),    32'(e.ese));
            cmp("locked",      idx, 32'(locked),      32'(e.elk));
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        fsync     = 1'b0;

        // Basic frame A1..D4, then a slot-0 fsync that must not flag an error
        vecs.push_back(mk(1,0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'hA1, 8'hA1,8'h00,8'h00,8'h00, 4'b0001,0,0,1));
        vecs.push_back(mk(0,1,0,8'hB2, 8'hA1,8'hB2,8'h00,8'h00, 4'b0010,0,0,1));
        vecs.push_back(mk(0,1,0,8'hC3, 8'hA1,8'hB2,8'hC3,8'h00, 4'b0100,0,0,1));
        vecs.push_back(mk(0,1,0,8'hD4, 8'hA1,8'hB2,8'hC3,8'hD4, 4'b1000,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00, 8'hA1,8'hB2,8'hC3,8'hD4, 4'b0000,0,0,1));
        vecs.push_back(mk(0,1,1,8'hE5, 8'hE5,8'hB2,8'hC3,8'hD4, 4'b0001,0,0,1));

        // Five unsynchronised words from reset are all discarded
        vecs.push_back(mk(1,0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0,1,0,8'(8'h10 + i), 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        end

        // Early fsync on 33 resynchronises; only the 33..66 frame completes
        vecs.push_back(mk(1,0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'h11, 8'h11,8'h00,8'h00,8'h00, 4'b0001,0,0,1));
        vecs.push_back(mk(0,1,0,8'h22, 8'h11,8'h22,8'h00,8'h00, 4'b0010,0,0,1));
        vecs.push_back(mk(0,1,1,8'h33, 8'h33,8'h22,8'h00,8'h00, 4'b0001,0,1,1));
        vecs.push_back(mk(0,1,0,8'h44, 8'h33,8'h44,8'h00,8'h00, 4'b0010,0,0,1));
        vecs.push_back(mk(0,1,0,8'h55, 8'h33,8'h44,8'h55,8'h00, 4'b0100,0,0,1));
        vecs.push_back(mk(0,1,0,8'h66, 8'h33,8'h44,8'h55,8'h66, 4'b1000,1,0,1));

        // Missing fsync on a fifth word drops to HUNT; next fsync relocks
        vecs.push_back(mk(1,0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'h01, 8'h01,8'h00,8'h00,8'h00, 4'b0001,0,0,1));
        vecs.push_back(mk(0,1,0,8'h02, 8'h01,8'h02,8'h00,8'h00, 4'b0010,0,0,1));
        vecs.push_back(mk(0,1,0,8'h03, 8'h01,8'h02,8'h03,8'h00, 4'b0100,0,0,1));
        vecs.push_back(mk(0,1,0,8'h04, 8'h01,8'h02,8'h03,8'h04, 4'b1000,1,0,1));
        vecs.push_back(mk(0,1,0,8'h77, 8'h01,8'h02,8'h03,8'h04, 4'b0000,0,1,0));
        vecs.push_back(mk(0,1,0,8'h88, 8'h01,8'h02,8'h03,8'h04, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'h99, 8'h99,8'h02,8'h03,8'h04, 4'b0001,0,0,1));

        // Frame with three idle cycles between words; fsync on an idle cycle is ignored
        vecs.push_back(mk(1,0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'hA1, 8'hA1,8'h00,8'h00,8'h00, 4'b0001,0,0,1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,(i==1),8'hFF, 8'hA1,8'h00,8'h00,8'h00, 4'b0000,0,0,1));
        vecs.push_back(mk(0,1,0,8'hB2, 8'hA1,8'hB2,8'h00,8'h00, 4'b0010,0,0,1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,8'hEE, 8'hA1,8'hB2,8'h00,8'h00, 4'b0000,0,0,1));
        vecs.push_back(mk(0,1,0,8'hC3, 8'hA1,8'hB2,8'hC3,8'h00, 4'b0100,0,0,1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,1,8'hDD, 8'hA1,8'hB2,8'hC3,8'h00, 4'b0000,0,0,1));
        vecs.push_back(mk(0,1,0,8'hD4, 8'hA1,8'hB2,8'hC3,8'hD4, 4'b1000,1,0,1));

        // Reset on the slot-2 word (with valid+fsync) wins; relock needs fsync
        vecs.push_back(mk(1,0,0,8'h00, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'hA1, 8'hA1,8'h00,8'h00,8'h00, 4'b0001,0,0,1));
        vecs.push_back(mk(0,1,0,8'hB2, 8'hA1,8'hB2,8'h00,8'h00, 4'b0010,0,0,1));
        vecs.push_back(mk(1,1,1,8'hC3, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,0,8'hD4, 8'h00,8'h00,8'h00,8'h00, 4'b0000,0,0,0));
        vecs.push_back(mk(0,1,1,8'h5A, 8'h5A,8'h00,8'h00,8'h00, 4'b0001,0,0,1));
        vecs.push_back(mk(0,1,0,8'h6B, 8'h5A,8'h6B,8'h00,8'h00, 4'b0010,0,0,1));
        vecs.push_back(mk(0,1,0,8'h7C, 8'h5A,8'h6B,8'h7C,8'h00, 4'b0100,0,0,1));
        vecs.push_back(mk(0,1,0,8'h8D, 8'h5A,8'h6B,8'h7C,8'h8D, 4'b1000,1,0,1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
